hc164_chain_ctrl: RTL
=====================

// Module: hc164_chain_ctrl
// PURPOSE
//  Sequencer for a cascade of NUM_SR 74HC164 serial-in/parallel-out registers.
//  Accepts a parallel word on a valid/ready handshake and bit-bangs it MSB-first
//  onto the chain's shared clock/data pins, then pulses done. Also generates the
//  chain's active-low clear (after reset and on request). Drives hc164 instances.
// PARAMETERS
//  NUM_SR  2  number of cascaded hc164 devices; NBITS = 8*NUM_SR
//  DIV     4  clk cycles per sr_clk half-period (and per clear pulse); DIV >= 1
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  clr_n      in   1        asynchronous active-low reset
//  s_valid    in   1        word available
//  s_ready    out  1        controller can accept (combinational, see below)
//  s_data     in   NBITS    word; bit NBITS-1 shifted first
//  clear_req  in   1        request chain clear (single-cycle sample in IDLE)
//  busy       out  1        registered; 1 in any state other than IDLE
//  done       out  1        registered one-cycle pulse at end of a shift transfer
//  sr_clk     out  1        to every hc164 clk
//  sr_d       out  1        to device 0 d_in (device k q[7] feeds device k+1)
//  sr_clr_n   out  1        to every hc164 clr_n
// BEHAVIOUR
//  - Clock/reset: one clock clk; reset clr_n asynchronous, active-low.
//  - Reset values: state=CLEAR, cnt=0, sr_clk=0, sr_d=0, sr_clr_n=0, done=0, busy=1.
//  - All pin outputs registered; sr_clk/sr_d/sr_clr_n glitch-free.
//  - States: IDLE, CLEAR, LOW, HIGH. Phase counter counts DIV cycles per state.
//  - CLEAR: sr_clr_n=0, sr_clk=0 for DIV cycles, then IDLE with sr_clr_n=1.
//    After reset release the chain is therefore held clear DIV more cycles.
//  - IDLE: s_ready = (state==IDLE) && !clear_req. clear_req wins over s_valid
//    in the same cycle -> CLEAR. Handshake (s_valid&&s_ready) latches s_data
//    into shift reg, bit counter=NBITS -> LOW.
//  - LOW: sr_clk=0, sr_d=shreg[NBITS-1] set on entry, held DIV cycles -> HIGH.
//  - HIGH: sr_clk=1 for DIV cycles (rising edge at entry; sr_d unchanged). On exit
//    shreg<<=1, count-1; if count reaches 0 -> IDLE, sr_clk=0, done=1 for 1 cycle;
//    else -> LOW.
//  - Latency: accept to done = 2*DIV*NBITS cycles; exactly NBITS sr_clk rising edges.
//  - Result: device k q[j] = s_data[8*k+j] (device NUM_SR-1 q[7] = MSB).
//  - Back-to-back: s_ready high in the done cycle; next word may be accepted then.
//  - clear_req while busy: ignored, not queued. s_data changes after accept: ignored.
//  - Reset mid-transfer: outputs to reset values immediately, word discarded, no done.
//  - Chain outputs ripple during shifting (no output latch on hc164); consumers
//    sample only after done.
// CONFIGURATION
//  HC_CHAIN_CLR_ON_LOAD_EN
//   defined: each accepted word first runs a CLEAR phase (DIV cycles, sr_clr_n=0)
//     then LOW/HIGH shifting; accept-to-done = DIV + 2*DIV*NBITS cycles; busy
//     covers the clear phase.
//   undefined: no clear per word; chain cleared only after reset or clear_req.
// TESTING (NUM_SR=2, DIV=2, chain = two hc164 models, macro undefined unless noted)
//  1 release clr_n -> sr_clr_n=0 for 2 cycles then 1; s_ready first high in IDLE.
//  2 send 16'hA5C3 -> 16 sr_clk rising edges, done 64 cycles after accept,
//    chain {dev1.q,dev0.q}=16'hA5C3, sr_d stable across every rising edge.
//  3 s_valid held with 16'h0001 then 16'hFFFF back-to-back -> second accepted in
//    done cycle, chain reads 16'hFFFF after second done; no idle gap > 1 cycle.
//  4 clear_req and s_valid same IDLE cycle -> s_ready=0, sr_clr_n=0 2 cycles, then
//    word accepted; clear_req pulsed while busy -> no effect on sr_clr_n.
//  5 assert clr_n low at bit 7 of a transfer -> sr_clk=0, sr_clr_n=0 same cycle,
//    chain reads 16'h0000, no done pulse.
//  6 macro defined, send 16'h8000 over prior 16'hFFFF -> sr_clr_n low 2 cycles
//    post-accept, done at 66 cycles, chain = 16'h8000.

Source files
------------

// File: rtl/hc164_chain_ctrl.sv
// hc164_chain_ctrl: sequencer for a cascade of NUM_SR 74HC164 shift registers.
// Accepts a parallel word on a valid/ready handshake and shifts it MSB-first
// onto the shared sr_clk/sr_d pins, then pulses done. It also drives the chain's
// active-low clear after reset and on clear_req.
// Optional build macro: HC_CHAIN_CLR_ON_LOAD_EN -- when defined, every accepted
// word is preceded by a DIV-cycle chain clear.
module hc164_chain_ctrl #(
  parameter int unsigned NUM_SR = 2,
  parameter int unsigned DIV    = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [8*NUM_SR-1:0]   s_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  done,
  output logic                  sr_clk,
  output logic                  sr_d,
  output logic                  sr_clr_n
);

  localparam int unsigned NBITS = 8 * NUM_SR;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(NBITS);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOW   = 2'd2,
    ST_HIGH  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIT_W-1:0]   r_bits;
  logic [NBITS-1:0]   r_shreg;
  logic               r_busy;
  logic               r_done;
  logic               r_sr_clk;
  logic               r_sr_d;
  logic               r_sr_clr_n;
`ifdef HC_CHAIN_CLR_ON_LOAD_EN
  logic               r_load_pend;
`endif

  logic               w_phase_end;
  logic               w_accept;

  // Handshake: ready only while idle and no clear is being requested
  assign s_ready     = (r_state == ST_IDLE) && !clear_req;
  assign w_accept    = s_valid && s_ready;
  assign w_phase_end = (r_cnt == CNT_LAST);

  assign busy     = r_busy;
  assign done     = r_done;
  assign sr_clk   = r_sr_clk;
  assign sr_d     = r_sr_d;
  assign sr_clr_n = r_sr_clr_n;

  // Sequencer FSM with registered pin outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_shreg     <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_sr_clk    <= 1'b0;
      r_sr_d      <= 1'b0;
      r_sr_clr_n  <= 1'b0;
`ifdef HC_CHAIN_CLR_ON_LOAD_EN
      r_load_pend <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (clear_req) begin
            // clear_req takes priority over a pending word
            r_state    <= ST_CLEAR;
            r_sr_clr_n <= 1'b0;
            r_sr_clk   <= 1'b0;
            r_busy     <= 1'b1;
          end else if (w_accept) begin
            r_shreg <= s_data;
            r_bits  <= BIT_FULL;
            r_busy  <= 1'b1;
`ifdef HC_CHAIN_CLR_ON_LOAD_EN
            r_state     <= ST_CLEAR;
            r_sr_clr_n  <= 1'b0;
            r_sr_clk    <= 1'b0;
            r_load_pend <= 1'b1;
`else
            r_state  <= ST_LOW;
            r_sr_clk <= 1'b0;
            r_sr_d   <= s_data[NBITS-1];
`endif
          end
        end

        ST_CLEAR: begin
          if (w_phase_end) begin
            r_cnt      <= '0;
            r_sr_clr_n <= 1'b1;
`ifdef HC_CHAIN_CLR_ON_LOAD_EN
            if (r_load_pend) begin
              // clear before load finished: present the MSB and start shifting
              r_load_pend <= 1'b0;
              r_state     <= ST_LOW;
              r_sr_d      <= r_shreg[NBITS-1];
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (w_phase_end) begin
            // rising sr_clk edge; data has been stable for DIV cycles
            r_cnt    <= '0;
            r_state  <= ST_HIGH;
            r_sr_clk <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_HIGH: begin
          if (w_phase_end) begin
            r_cnt    <= '0;
            r_sr_clk <= 1'b0;
            r_shreg  <= r_shreg << 1;
            r_bits   <= r_bits - BIT_ONE;
            if (r_bits == BIT_ONE) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_LOW;
              r_sr_d  <= r_shreg[NBITS-2];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state    <= ST_CLEAR;
          r_cnt      <= '0;
          r_sr_clr_n <= 1'b0;
          r_sr_clk   <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
